regwei_pingpong: RTL
====================

# regwei_pingpong

Double-banked weight register file between the weight SRAM and the PE multiply-accumulate lanes. It holds two aligned blocks of `WR_NUM` weights and serves `RD_NUM` independent readers by absolute weight address. It refills on a miss and, optionally, prefetches the next block into the idle bank, so a reader advancing into the next block sees no stall.

## Interface
- `DATA_WIDTH`, 8: weight word width.
- `ADDR_WIDTH`, 12: absolute weight address width.
- `REG_ADDR_WIDTH`, 3: word offset width inside a block; `WR_NUM = 2**REG_ADDR_WIDTH` (derived, not overridable).
- `RD_NUM`, 4: number of reader ports.
- `PREFETCH`, 1: 1 enables next-block prefetch; 0 gives miss-only refill.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `datain_rdy`, out, 1: registered request to SRAM; asserted throughout FILL.
- `datain_addr`, out, `ADDR_WIDTH`: requested block index (address >> `REG_ADDR_WIDTH`), zero-extended.
- `datain_val`, in, 1: SRAM block valid.
- `datain`, in, `DATA_WIDTH*WR_NUM`: word i in slice i.
- `dataout_addr`, in, `ADDR_WIDTH*RD_NUM`: per-reader absolute address.
- `dataout_rdy`, in, `RD_NUM`: reader requests a word.
- `dataout_val`, out, `RD_NUM`: word delivered this cycle.
- `dataout`, out, `DATA_WIDTH*RD_NUM`: per-reader word.

## Operation
- Per bank b in {0,1}: `valid[b]`, `tag[b]` (block index), `WR_NUM` words. Register `last` holds the most recently filled bank.
- For reader j, blk_j = addr_j >> R and off_j = addr_j[R-1:0].
  - hit_j: rdy_j and some b has valid[b] and tag[b]==blk_j.
  - `dataout_val[j]` = hit_j; `dataout` = bank word at off_j. Both combinational from registers.
  - miss_j: rdy_j and not hit_j.
- The two valid banks never hold equal tags.
- FSM states:
  - IDLE: `datain_rdy`=0.
    - If any miss_j: take the lowest j. Latch `datain_addr`=blk_j and `fill_bank`. `fill_bank` is the lowest invalid bank, otherwise ~`last`. Clear `valid[fill_bank]` and go to FILL.
    - Else, if `PREFETCH`, `valid[last]`, `tag[~last]` != `tag[last]`+1 (or `valid[~last]`=0), and no ready reader hits bank ~`last`: latch `datain_addr`=`tag[last]`+1 and `fill_bank`=~`last`. The +1 is modulo 2^(`ADDR_WIDTH`-R). Clear `valid[~last]` and go to FILL.
    - Else stay in IDLE.
  - FILL: `datain_rdy`=1.
    - On `datain_val`: write all `WR_NUM` words to `fill_bank`, set `valid`=1, `tag`=`datain_addr`, `last`=`fill_bank`, then go to IDLE.
    - A committed request is never aborted; new misses wait for IDLE.
- `datain_val` while `datain_rdy`=0 is ignored.
- Reset values: state IDLE; valid=00; tags 0; words 0; `last`=1; `datain_addr`=0; `datain_rdy`=0. Outputs `dataout_val`=0 and `dataout`=0.
- `reset` mid-FILL drops the request. `datain_rdy` is 0 in the cycle after reset.

## Timing
- A miss is seen in IDLE in cycle N. The FSM enters FILL at N+1 with `datain_rdy`=1. The block is accepted at cycle M ≥ N+1 when `datain_val`=1. FSM returns to IDLE at M+1.
- Data written at M is readable from M+1.
- Minimum miss-to-hit latency: 2 cycles.
- Back-to-back fills: a miss still present at M+1 enters FILL at M+2.
- Writing a bank that no reader hits causes no output glitch. The filled bank is invalid from FILL entry to M+1.
- With `PREFETCH`=1 and block t resident, block t+1 is resident within 2 cycles of SRAM latency plus 1. A reader crossing the boundary then sees continuous `dataout_val`.

## Structure
- Shared package `regwei_pkg`: FSM state encoding (IDLE=0, FILL=1) and the `WR_NUM` derivation function.
- Sub-module `regwei_bank`, instantiated twice:
  - `WR_NUM` words with one wide write port and `RD_NUM` combinational read ports.
  - Sync-reset clear.
- Top level holds the tag, valid and `last` registers, the hit/miss compare, the FSM and the output mux.

## Test plan
- Reset, then reader0 requests addr 0x013, with SRAM returning on the 1st `datain_rdy` cycle.
  - Required: `datain_addr`=2 and FILL into bank 0; `dataout_val[0]`=1 two cycles after the request, with word 3 of block 2.
- `PREFETCH`=1, reader0 sweeps 0x010..0x01F one address per cycle, SRAM 1-cycle latency.
  - Required: prefetch of block 3 into bank 1; `dataout_val[0]` stays high across 0x017→0x018.
- Readers 0 and 2 miss on blocks 5 and 9 in the same cycle.
  - Required: block 5 fetched first, then block 9 into the other bank.
  - Required: the second fill enters FILL the cycle after the first returns to IDLE.
- `datain_val` pulsed while `datain_rdy`=0.
  - Required: no bank or tag change.
- `reset` asserted while FILL waits for block 7.
  - Required next cycle: `datain_rdy`=0, valid=00, all `dataout_val`=0.
  - A later `datain_val` is ignored.
- `PREFETCH`=0, block index 0x1FF resident, reader requests 0x000.
  - Required: miss fill of block 0 only, no wrap prefetch.
  - `PREFETCH`=1 variant: prefetch requests block 0 (wrap).

Source files
------------

// File: rtl/regwei_pkg.sv
// Shared definitions for the ping-pong weight register file.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package regwei_pkg;

  // Refill controller state. IDLE=0, FILL=1.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  // Words per block. Derived from the offset width and not overridable.
  function automatic int wr_num_f(input int reg_addr_width);
    return 1 << reg_addr_width;
  endfunction

endpackage

// File: rtl/regwei_bank.sv
// One weight block: a wide single write port and RD_NUM combinational read ports.
// Latency: a write is visible on the read ports from the next cycle; reads are 0-cycle.
// Backpressure: none; the write is accepted whenever wr_en is high.
//
// Ports:
//   clk, reset : clock and synchronous active-high clear of all words
//   wr_en      : load all WR_NUM words from wr_data (word i in slice i)
//   rd_off     : per-reader word offset, RD_NUM slices of REG_ADDR_WIDTH
//   rd_data    : per-reader word, RD_NUM slices of DATA_WIDTH
module regwei_bank import regwei_pkg::*; #(
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int RD_NUM         = 4
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           wr_en,
  input  logic [DATA_WIDTH*wr_num_f(REG_ADDR_WIDTH)-1:0] wr_data,
  input  logic [REG_ADDR_WIDTH*RD_NUM-1:0]               rd_off,
  output logic [DATA_WIDTH*RD_NUM-1:0]                   rd_data
);

  localparam int WR_NUM = wr_num_f(REG_ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] word_q [WR_NUM];
  logic [DATA_WIDTH-1:0] word_d [WR_NUM];

  always_comb begin
    for (int i = 0; i < WR_NUM; i++) begin
      word_d[i] = wr_en ? wr_data[i*DATA_WIDTH +: DATA_WIDTH] : word_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WR_NUM; i++) word_q[i] <= '0;
    end else begin
      for (int i = 0; i < WR_NUM; i++) word_q[i] <= word_d[i];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int j = 0; j < RD_NUM; j++) begin
      rd_data[j*DATA_WIDTH +: DATA_WIDTH] = word_q[rd_off[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]];
    end
  end

endmodule

// File: rtl/regwei_pingpong.sv
// Two-bank weight register file serving RD_NUM readers by absolute address, with miss refill and next-block prefetch.
// Latency: hit is 0-cycle from registers; miss-to-hit is 2 cycles plus SRAM wait.
// Backpressure: a missing reader sees dataout_val low until its block lands; the SRAM side holds datain_rdy until datain_val.
//
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   datain_rdy / datain_addr : block request to the weight SRAM (block index, zero-extended)
//   datain_val / datain      : SRAM block return, word i in slice i
//   dataout_addr/dataout_rdy : per-reader absolute address and request
//   dataout_val / dataout    : per-reader hit flag and word (0 when not hitting)
module regwei_pingpong import regwei_pkg::*; #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int RD_NUM         = 4,
  parameter int PREFETCH       = 1
) (
  input  logic                                           clk,
  input  logic                                           reset,
  output logic                                           datain_rdy,
  output logic [ADDR_WIDTH-1:0]                          datain_addr,
  input  logic                                           datain_val,
  input  logic [DATA_WIDTH*wr_num_f(REG_ADDR_WIDTH)-1:0] datain,
  input  logic [ADDR_WIDTH*RD_NUM-1:0]                   dataout_addr,
  input  logic [RD_NUM-1:0]                              dataout_rdy,
  output logic [RD_NUM-1:0]                              dataout_val,
  output logic [DATA_WIDTH*RD_NUM-1:0]                   dataout
);

  localparam int TAG_W = ADDR_WIDTH - REG_ADDR_WIDTH;

  state_e           state_q, state_d;
  logic [1:0]       valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [2];
  logic [TAG_W-1:0] tag_d [2];
  logic             last_q, last_d;
  logic             fill_bank_q, fill_bank_d;
  logic [TAG_W-1:0] req_q, req_d;

  logic [TAG_W-1:0]             blk [RD_NUM];
  logic [REG_ADDR_WIDTH*RD_NUM-1:0] off_pk;
  logic [RD_NUM-1:0]            hit0, hit1, miss;
  logic [DATA_WIDTH*RD_NUM-1:0] rd0, rd1;
  logic [TAG_W-1:0]             miss_blk;
  logic [TAG_W-1:0]             next_blk;
  logic                         idle_bank_busy;
  logic                         wr0, wr1;

  // Reader address split and tag compare. Valid banks never share a tag,
  // so at most one of hit0/hit1 is set per reader.
  always_comb begin
    off_pk = '0;
    hit0   = '0;
    hit1   = '0;
    miss   = '0;
    for (int j = 0; j < RD_NUM; j++) begin
      blk[j] = dataout_addr[j*ADDR_WIDTH+REG_ADDR_WIDTH +: TAG_W];
      off_pk[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] =
        dataout_addr[j*ADDR_WIDTH +: REG_ADDR_WIDTH];
      hit0[j] = dataout_rdy[j] & valid_q[0] & (tag_q[0] == blk[j]);
      hit1[j] = dataout_rdy[j] & valid_q[1] & (tag_q[1] == blk[j]);
      miss[j] = dataout_rdy[j] & ~(hit0[j] | hit1[j]);
    end
  end

  assign wr0 = (state_q == ST_FILL) && datain_val && (fill_bank_q == 1'b0);
  assign wr1 = (state_q == ST_FILL) && datain_val && (fill_bank_q == 1'b1);

  regwei_bank #(
    .DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .RD_NUM(RD_NUM)
  ) u_bank0 (
    .clk(clk), .reset(reset), .wr_en(wr0), .wr_data(datain), .rd_off(off_pk), .rd_data(rd0)
  );

  regwei_bank #(
    .DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .RD_NUM(RD_NUM)
  ) u_bank1 (
    .clk(clk), .reset(reset), .wr_en(wr1), .wr_data(datain), .rd_off(off_pk), .rd_data(rd1)
  );

  // Output mux: a non-hitting reader gets zero so a bank being refilled
  // never leaks onto a lane.
  always_comb begin
    dataout_val = hit0 | hit1;
    dataout     = '0;
    for (int j = 0; j < RD_NUM; j++) begin
      if (hit0[j])      dataout[j*DATA_WIDTH +: DATA_WIDTH] = rd0[j*DATA_WIDTH +: DATA_WIDTH];
      else if (hit1[j]) dataout[j*DATA_WIDTH +: DATA_WIDTH] = rd1[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign datain_rdy  = (state_q == ST_FILL);
  assign datain_addr = {{REG_ADDR_WIDTH{1'b0}}, req_q};

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    last_d      = last_q;
    fill_bank_d = fill_bank_q;
    req_d       = req_q;

    // Scan downward so the lowest-numbered missing reader wins.
    miss_blk = '0;
    for (int j = RD_NUM - 1; j >= 0; j--) begin
      if (miss[j]) miss_blk = blk[j];
    end

    // Wraps modulo 2**TAG_W by width truncation.
    next_blk = tag_q[last_q] + 1'b1;
    // Prefetch must not evict a bank a reader is using right now.
    idle_bank_busy = last_q ? (|hit0) : (|hit1);

    case (state_q)
      ST_IDLE: begin
        if (|miss) begin
          req_d = miss_blk;
          if (!valid_q[0])      fill_bank_d = 1'b0;
          else if (!valid_q[1]) fill_bank_d = 1'b1;
          else                  fill_bank_d = ~last_q;
          valid_d[fill_bank_d] = 1'b0;
          state_d = ST_FILL;
        end else if ((PREFETCH != 0) && valid_q[last_q] &&
                     (!valid_q[~last_q] || (tag_q[~last_q] != next_blk)) &&
                     !idle_bank_busy) begin
          req_d            = next_blk;
          fill_bank_d      = ~last_q;
          valid_d[~last_q] = 1'b0;
          state_d          = ST_FILL;
        end
      end
      ST_FILL: begin
        // The request stays committed until the SRAM answers.
        if (datain_val) begin
          valid_d[fill_bank_q] = 1'b1;
          tag_d[fill_bank_q]   = req_q;
          last_d               = fill_bank_q;
          state_d              = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      valid_q     <= 2'b00;
      tag_q[0]    <= '0;
      tag_q[1]    <= '0;
      last_q      <= 1'b1;
      fill_bank_q <= 1'b0;
      req_q       <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      tag_q[0]    <= tag_d[0];
      tag_q[1]    <= tag_d[1];
      last_q      <= last_d;
      fill_bank_q <= fill_bank_d;
      req_q       <= req_d;
    end
  end

endmodule
